// File: rtl/e203_exu_longpwbck_mc.sv
// rtl/e203_exu_longpwbck_mc.sv - buffered multi-channel long-pipe writeback arbiter
// Retires OITF entries in order and queues results for writeback or commit.
module e203_exu_longpwbck_mc #(
  parameter int NCH       = 2,
  parameter int XLEN      = 32,
  parameter int ITAG_W    = 1,
  parameter int RFIDX_W   = 5,
  parameter int ADDR_W    = 32,
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          ch_wbck_i_valid,
  output logic [NCH-1:0]          ch_wbck_i_ready,
  input  logic [NCH*XLEN-1:0]     ch_wbck_i_wdat,
  input  logic [NCH*5-1:0]        ch_wbck_i_flags,
  input  logic [NCH*ITAG_W-1:0]   ch_wbck_i_itag,
  input  logic [NCH-1:0]          ch_wbck_i_err,
  input  logic [NCH-1:0]          ch_cmt_i_buserr,
  input  logic [NCH-1:0]          ch_cmt_i_ld,
  input  logic [NCH-1:0]          ch_cmt_i_st,
  input  logic [NCH*ADDR_W-1:0]   ch_cmt_i_badaddr,
  input  logic                    oitf_empty,
  input  logic [ITAG_W-1:0]       oitf_ret_ptr,
  input  logic [RFIDX_W-1:0]      oitf_ret_rdidx,
  input  logic [PC_W-1:0]         oitf_ret_pc,
  input  logic                    oitf_ret_rdwen,
  output logic                    oitf_ret_ena,
  output logic                    longp_wbck_o_valid,
  input  logic                    longp_wbck_o_ready,
  output logic [XLEN-1:0]         longp_wbck_o_wdat,
  output logic [4:0]              longp_wbck_o_flags,
  output logic [RFIDX_W-1:0]      longp_wbck_o_rdidx,
  output logic                    longp_excp_o_valid,
  input  logic                    longp_excp_o_ready,
  output logic                    longp_excp_o_insterr,
  output logic                    longp_excp_o_ld,
  output logic                    longp_excp_o_st,
  output logic                    longp_excp_o_buserr,
  output logic [ADDR_W-1:0]       longp_excp_o_badaddr,
  output logic [PC_W-1:0]         longp_excp_o_pc,
  output logic                    longp_buf_empty
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  logic [XLEN-1:0]    buf_wdat    [BUF_DEPTH];
  logic [4:0]         buf_flags   [BUF_DEPTH];
  logic [RFIDX_W-1:0] buf_rdidx   [BUF_DEPTH];
  logic               buf_rdwen   [BUF_DEPTH];
  logic               buf_err     [BUF_DEPTH];
  logic               buf_ld      [BUF_DEPTH];
  logic               buf_st      [BUF_DEPTH];
  logic               buf_buserr  [BUF_DEPTH];
  logic [ADDR_W-1:0]  buf_badaddr [BUF_DEPTH];
  logic [PC_W-1:0]    buf_pc      [BUF_DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, pop, push, can_push, any_match;
  logic [SEL_W-1:0] sel;
  logic [XLEN-1:0]  sel_wdat;
  logic [4:0]       sel_flags;
  logic             sel_err, sel_ld, sel_st, sel_buserr;
  logic [ADDR_W-1:0] sel_badaddr;
  logic             head_wb, head_ex, head_nop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    any_match   = 1'b0;
    sel         = '0;
    sel_wdat    = '0;
    sel_flags   = '0;
    sel_err     = 1'b0;
    sel_ld      = 1'b0;
    sel_st      = 1'b0;
    sel_buserr  = 1'b0;
    sel_badaddr = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (ch_wbck_i_valid[k] && (ch_wbck_i_itag[k*ITAG_W +: ITAG_W] == oitf_ret_ptr) && !oitf_empty) begin
        any_match   = 1'b1;
        sel         = SEL_W'(k);
        sel_wdat    = ch_wbck_i_wdat[k*XLEN +: XLEN];
        sel_flags   = ch_wbck_i_flags[k*5 +: 5];
        sel_err     = ch_wbck_i_err[k];
        sel_ld      = ch_cmt_i_ld[k];
        sel_st      = ch_cmt_i_st[k];
        sel_buserr  = ch_cmt_i_buserr[k];
        sel_badaddr = ch_cmt_i_badaddr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign head_wb  = buf_rdwen[rd_ptr] & ~buf_err[rd_ptr];
  assign head_ex  = buf_err[rd_ptr];
  assign head_nop = ~buf_rdwen[rd_ptr] & ~buf_err[rd_ptr];

  assign pop      = ~empty & ((head_wb & longp_wbck_o_ready) | (head_ex & longp_excp_o_ready) | head_nop);
  assign can_push = ~full | pop;
  assign push     = any_match & can_push;
  assign oitf_ret_ena = push;

  always_comb begin
    ch_wbck_i_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_wbck_i_ready[k] = any_match && (sel == SEL_W'(k)) && can_push;
    end
  end

  // Fault side-band is zeroed for clean results so it can never leak into commit.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_wdat[wr_ptr]    <= sel_wdat;
      buf_flags[wr_ptr]   <= sel_flags;
      buf_rdidx[wr_ptr]   <= oitf_ret_rdidx;
      buf_rdwen[wr_ptr]   <= oitf_ret_rdwen;
      buf_err[wr_ptr]     <= sel_err;
      buf_ld[wr_ptr]      <= sel_err & sel_ld;
      buf_st[wr_ptr]      <= sel_err & sel_st;
      buf_buserr[wr_ptr]  <= sel_err & sel_buserr;
      buf_badaddr[wr_ptr] <= sel_err ? sel_badaddr : '0;
      buf_pc[wr_ptr]      <= oitf_ret_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign longp_wbck_o_valid   = ~empty & head_wb;
  assign longp_excp_o_valid   = ~empty & head_ex;
  assign longp_wbck_o_wdat    = buf_wdat[rd_ptr];
  assign longp_wbck_o_flags   = buf_flags[rd_ptr];
  assign longp_wbck_o_rdidx   = buf_rdidx[rd_ptr];
  assign longp_excp_o_insterr = 1'b0;
  assign longp_excp_o_ld      = buf_ld[rd_ptr];
  assign longp_excp_o_st      = buf_st[rd_ptr];
  assign longp_excp_o_buserr  = buf_buserr[rd_ptr];
  assign longp_excp_o_badaddr = buf_badaddr[rd_ptr];
  assign longp_excp_o_pc      = buf_pc[rd_ptr];
  assign longp_buf_empty      = empty;

endmodule

// File: tb/tb_e203_exu_longpwbck_mc.sv
// tb/tb_e203_exu_longpwbck_mc.sv - randomized bench with queue reference model
// Directed scenarios pin the model; a random phase compares every cycle.
module tb_e203_exu_longpwbck_mc;
  localparam int NCH = 2, XLEN = 32, ITW = 1, RFW = 5, AW = 32, PCW = 32, DEPTH = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0] ch_valid, ch_ready, ch_err, ch_buserr, ch_ld, ch_st;
  logic [NCH*XLEN-1:0] ch_wdat;
  logic [NCH*5-1:0] ch_flags;
  logic [NCH*ITW-1:0] ch_itag;
  logic [NCH*AW-1:0] ch_badaddr;
  logic oitf_empty, oitf_rdwen, ret_ena;
  logic [ITW-1:0] ret_ptr;
  logic [RFW-1:0] ret_rdidx;
  logic [PCW-1:0] ret_pc;
  logic wv, wr, ev, er, insterr, eld, est, ebus, buf_empty;
  logic [XLEN-1:0] wdat;
  logic [4:0] wflags;
  logic [RFW-1:0] wrdidx;
  logic [AW-1:0] ebad;
  logic [PCW-1:0] epc;

  int total = 0, bad = 0;

  typedef struct {
    logic [31:0] wdat; logic [4:0] flags; logic [4:0] rdidx;
    logic rdwen, err, ld, st, buserr; logic [31:0] badaddr, pc;
  } ent_t;
  ent_t q[$];

  e203_exu_longpwbck_mc #(.NCH(NCH), .XLEN(XLEN), .ITAG_W(ITW), .RFIDX_W(RFW),
    .ADDR_W(AW), .PC_W(PCW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_wbck_i_valid(ch_valid), .ch_wbck_i_ready(ch_ready), .ch_wbck_i_wdat(ch_wdat),
    .ch_wbck_i_flags(ch_flags), .ch_wbck_i_itag(ch_itag), .ch_wbck_i_err(ch_err),
    .ch_cmt_i_buserr(ch_buserr), .ch_cmt_i_ld(ch_ld), .ch_cmt_i_st(ch_st),
    .ch_cmt_i_badaddr(ch_badaddr), .oitf_empty(oitf_empty), .oitf_ret_ptr(ret_ptr),
    .oitf_ret_rdidx(ret_rdidx), .oitf_ret_pc(ret_pc), .oitf_ret_rdwen(oitf_rdwen),
    .oitf_ret_ena(ret_ena),
    .longp_wbck_o_valid(wv), .longp_wbck_o_ready(wr), .longp_wbck_o_wdat(wdat),
    .longp_wbck_o_flags(wflags), .longp_wbck_o_rdidx(wrdidx),
    .longp_excp_o_valid(ev), .longp_excp_o_ready(er), .longp_excp_o_insterr(insterr),
    .longp_excp_o_ld(eld), .longp_excp_o_st(est), .longp_excp_o_buserr(ebus),
    .longp_excp_o_badaddr(ebad), .longp_excp_o_pc(epc), .longp_buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ch_valid = '0; ch_wdat = '0; ch_flags = '0; ch_itag = '0; ch_err = '0;
    ch_buserr = '0; ch_ld = '0; ch_st = '0; ch_badaddr = '0;
    oitf_empty = 1'b0; ret_ptr = '0; ret_rdidx = '0; ret_pc = '0; oitf_rdwen = 1'b1;
  endtask

  task automatic drive_ch(input int k, input logic [ITW-1:0] itag, input logic [31:0] d,
                          input logic e, input logic l, input logic b, input logic [31:0] ba);
    ch_valid[k] = 1'b1; ch_itag[k*ITW +: ITW] = itag; ch_wdat[k*XLEN +: XLEN] = d;
    ch_flags[k*5 +: 5] = d[4:0]; ch_err[k] = e; ch_ld[k] = l; ch_st[k] = 1'b0;
    ch_buserr[k] = b; ch_badaddr[k*AW +: AW] = ba;
  endtask

  // Called at a negedge: compare DUT against the queue model, then advance one clock.
  task automatic cycle();
    int sel; int n; ent_t h; ent_t e; logic xwv, xev, xpop, xcp; logic [NCH-1:0] xr;
    sel = -1;
    for (int k = 0; k < NCH; k++)
      if (sel < 0 && ch_valid[k] && ch_itag[k*ITW +: ITW] == ret_ptr && !oitf_empty) sel = k;
    n = q.size();
    h = '{default: '0};
    if (n > 0) h = q[0];
    xwv = (n > 0) && h.rdwen && !h.err;
    xev = (n > 0) && h.err;
    xpop = (n > 0) && ((xwv && wr) || (xev && er) || (!h.rdwen && !h.err));
    xcp = (n < DEPTH) || xpop;
    xr = '0;
    if (sel >= 0 && xcp) xr[sel] = 1'b1;
    chk("ready", ch_ready, xr);
    chk("ret_ena", ret_ena, (sel >= 0) && xcp);
    chk("wbck_valid", wv, xwv);
    chk("excp_valid", ev, xev);
    chk("buf_empty", buf_empty, n == 0);
    chk("insterr", insterr, 0);
    if (xwv) begin
      chk("wdat", wdat, h.wdat); chk("flags", wflags, h.flags); chk("rdidx", wrdidx, h.rdidx);
    end
    if (xev) begin
      chk("ld", eld, h.ld); chk("st", est, h.st); chk("buserr", ebus, h.buserr);
      chk("badaddr", ebad, h.badaddr); chk("pc", epc, h.pc);
    end
    if (sel >= 0 && xcp) begin
      e.wdat = ch_wdat[sel*XLEN +: XLEN]; e.flags = ch_flags[sel*5 +: 5];
      e.rdidx = ret_rdidx; e.rdwen = oitf_rdwen; e.err = ch_err[sel]; e.pc = ret_pc;
      e.ld = e.err & ch_ld[sel]; e.st = e.err & ch_st[sel]; e.buserr = e.err & ch_buserr[sel];
      e.badaddr = e.err ? ch_badaddr[sel*AW +: AW] : 32'h0;
    end
    @(posedge clk);
    if (xpop) void'(q.pop_front());
    if (sel >= 0 && xcp) q.push_back(e);
    #1;
  endtask

  initial begin
    idle(); wr = 1'b1; er = 1'b1; oitf_empty = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wv", wv, 0); chk("rst_ev", ev, 0); chk("rst_ret", ret_ena, 0);
    chk("rst_ready", ch_ready, 0); chk("rst_empty", buf_empty, 1);
    @(posedge clk); #1 rst_n = 1'b1; idle();

    // basic writeback
    drive_ch(0, 1'b0, 32'hDEADBEEF, 0, 0, 0, 0); ret_rdidx = 5;
    @(negedge clk); chk("wb_ready", ch_ready, 2'b01); chk("wb_ret", ret_ena, 1);
    cycle(); idle();
    @(negedge clk); chk("wb_v", wv, 1); chk("wb_rd", wrdidx, 5);
    chk("wb_d", wdat, 32'hDEADBEEF); chk("wb_ev", ev, 0);
    cycle();

    // load bus fault on ch1, held until excp_ready
    er = 1'b0; drive_ch(1, 1'b0, 32'h0, 1, 1, 1, 32'h80000004); ret_pc = 32'h100;
    @(negedge clk); chk("ex_ready", ch_ready, 2'b10); cycle(); idle();
    @(negedge clk); chk("ex_v", ev, 1); chk("ex_ld", eld, 1); chk("ex_bus", ebus, 1);
    chk("ex_ba", ebad, 32'h80000004); chk("ex_pc", epc, 32'h100); chk("ex_wv", wv, 0);
    cycle();
    @(negedge clk); chk("ex_hold", ev, 1); cycle();
    er = 1'b1; @(negedge clk); cycle();
    @(negedge clk); chk("ex_drained", buf_empty, 1); cycle();

    // NOP drain
    drive_ch(0, 1'b0, 32'h1234, 0, 0, 0, 0); oitf_rdwen = 1'b0;
    @(negedge clk); chk("nop_ret", ret_ena, 1); cycle(); idle();
    @(negedge clk); chk("nop_wv", wv, 0); chk("nop_ev", ev, 0); chk("nop_full", buf_empty, 0);
    cycle();
    @(negedge clk); chk("nop_empty", buf_empty, 1); cycle();

    // backpressure with three results
    wr = 1'b0;
    drive_ch(0, 1'b0, 32'hA, 0, 0, 0, 0); @(negedge clk); cycle();
    drive_ch(0, 1'b0, 32'hB, 0, 0, 0, 0); @(negedge clk); cycle();
    drive_ch(0, 1'b0, 32'hC, 0, 0, 0, 0);
    @(negedge clk); chk("bp_ready", ch_ready, 0); chk("bp_ret", ret_ena, 0); cycle();
    wr = 1'b1;
    @(negedge clk); chk("bp_ready2", ch_ready, 1); chk("bp_head_a", wdat, 32'hA); cycle();
    idle();
    @(negedge clk); chk("bp_head_b", wdat, 32'hB); cycle();
    @(negedge clk); chk("bp_head_c", wdat, 32'hC); cycle();
    @(negedge clk); cycle();

    // tag mismatch and priority
    drive_ch(0, 1'b1, 32'h11, 0, 0, 0, 0);
    @(negedge clk); chk("tag_miss", ch_ready, 0); cycle();
    drive_ch(1, 1'b0, 32'h22, 0, 0, 0, 0);
    @(negedge clk); chk("tag_ch1", ch_ready, 2'b10); cycle();
    drive_ch(0, 1'b0, 32'h33, 0, 0, 0, 0);
    @(negedge clk); chk("prio", ch_ready, 2'b01); cycle();
    idle(); oitf_empty = 1'b1; drive_ch(0, 1'b0, 32'h44, 0, 0, 0, 0);
    @(negedge clk); chk("oitf_empty", ch_ready, 0); cycle();
    idle(); repeat (3) begin @(negedge clk); cycle(); end

    // asynchronous reset with two entries in flight
    wr = 1'b0;
    drive_ch(0, 1'b0, 32'h55, 0, 0, 0, 0); @(negedge clk); cycle();
    drive_ch(0, 1'b0, 32'h66, 0, 0, 0, 0); @(negedge clk); cycle();
    idle(); rst_n = 1'b0; #1;
    chk("ar_wv", wv, 0); chk("ar_ev", ev, 0); chk("ar_empty", buf_empty, 1);
    q.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1; wr = 1'b1;
    @(negedge clk); chk("ar_stale", wv, 0); cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ch_valid = NCH'($urandom); ch_itag = NCH'($urandom); ch_err = NCH'($urandom);
      ch_ld = NCH'($urandom); ch_st = NCH'($urandom); ch_buserr = NCH'($urandom);
      ch_wdat = {$urandom, $urandom}; ch_flags = 10'($urandom);
      ch_badaddr = {$urandom, $urandom};
      oitf_empty = ($urandom_range(0, 9) == 0); ret_ptr = ITW'($urandom);
      ret_rdidx = RFW'($urandom); ret_pc = $urandom; oitf_rdwen = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 2) != 0); er = ($urandom_range(0, 2) != 0);
      @(negedge clk); cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
